// File: rtl/int_adder_result_stage.sv
// -----------------------------------------------------------------------------
// int_adder_result_stage
//
// Registered output stage behind the combinational integer adder. Each accepted
// adder result is stored together with its derived status flags (carry/borrow,
// zero, negative, signed overflow) and presented on a valid/ready interface.
// A main register plus one skid register give full throughput while keeping
// in_ready registered. A sticky overflow flag and a wrapping accepted-result
// counter are kept for software/debug visibility.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready upstream handshake (in_ready is registered)
//   in_sum, in_carry  adder sum and carry-out
//   in_a_msb          MSB of operand A
//   in_b_msb          MSB of operand B before any inversion
//   in_sub            1 = subtract (upstream inverted B, carry_in = 1)
//   out_valid/out_ready downstream handshake
//   out_result        registered sum
//   out_carry         add: carry, sub: borrow
//   out_zero, out_neg, out_ovf  result flags
//   ovf_sticky, ovf_clr         sticky overflow and its synchronous clear
//   result_cnt        number of results accepted downstream (wraps)
// -----------------------------------------------------------------------------
module int_adder_result_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_sum,
    input  logic                  in_carry,
    input  logic                  in_a_msb,
    input  logic                  in_b_msb,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_carry,
    output logic                  out_zero,
    output logic                  out_neg,
    output logic                  out_ovf,
    output logic                  ovf_sticky,
    input  logic                  ovf_clr,
    output logic [CNT_WIDTH-1:0]  result_cnt
);

    // Entry layout: {ovf, neg, zero, carry, sum}
    localparam int unsigned EW = DATA_WIDTH + 4;

    logic          flag_carry;
    logic          flag_zero;
    logic          flag_neg;
    logic          flag_ovf;
    logic [EW-1:0] in_entry;

    logic [EW-1:0]        main_q, main_d;
    logic                 main_vld_q, main_vld_d;
    logic [EW-1:0]        skid_q, skid_d;
    logic                 skid_vld_q, skid_vld_d;
    logic                 in_ready_q, in_ready_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic in_xfer;
    logic out_xfer;

    // Flags are derived from the raw adder outputs before registering. With
    // in_sub set, B was inverted upstream, so the effective B sign is
    // in_b_msb ^ in_sub and the adder carry-out is the inverse of a borrow.
    always_comb begin
        flag_carry = in_carry ^ in_sub;
        flag_zero  = (in_sum == '0);
        flag_neg   = in_sum[DATA_WIDTH-1];
        flag_ovf   = (in_a_msb == (in_b_msb ^ in_sub)) &&
                     (in_sum[DATA_WIDTH-1] != in_a_msb);
        in_entry   = {flag_ovf, flag_neg, flag_zero, flag_carry, in_sum};
    end

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = main_vld_q && out_ready;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        sticky_d   = sticky_q;
        cnt_d      = cnt_q;

        if (out_xfer) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = 1'b0;
            end
        end

        // in_ready is low whenever skid is full, so an input transfer never
        // coincides with the skid-to-main move above.
        if (in_xfer) begin
            if ((!main_vld_q || out_xfer) && !skid_vld_q) begin
                main_d     = in_entry;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = in_entry;
                skid_vld_d = 1'b1;
            end
        end

        // Setting on an overflowing transfer takes priority over the clear.
        if (out_xfer && main_q[DATA_WIDTH+3]) begin
            sticky_d = 1'b1;
        end else if (ovf_clr) begin
            sticky_d = 1'b0;
        end

        in_ready_d = !skid_vld_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_vld_q;
    assign out_result = main_q[DATA_WIDTH-1:0];
    assign out_carry  = main_q[DATA_WIDTH];
    assign out_zero   = main_q[DATA_WIDTH+1];
    assign out_neg    = main_q[DATA_WIDTH+2];
    assign out_ovf    = main_q[DATA_WIDTH+3];
    assign ovf_sticky = sticky_q;
    assign result_cnt = cnt_q;

endmodule

// File: tb/tb_int_adder_result_stage.sv
module tb_int_adder_result_stage;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_sum;
    logic          in_carry;
    logic          in_a_msb;
    logic          in_b_msb;
    logic          in_sub;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic          out_carry;
    logic          out_zero;
    logic          out_neg;
    logic          out_ovf;
    logic          ovf_sticky;
    logic          ovf_clr;
    logic [CW-1:0] result_cnt;

    int_adder_result_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .in_a_msb   (in_a_msb),
        .in_b_msb   (in_b_msb),
        .in_sub     (in_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr),
        .result_cnt (result_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       n;
        logic       o;
    } exp_t;

    exp_t          q[$];
    exp_t          cur;
    logic [CW-1:0] cnt_m;
    logic          sticky_m;
    int            n_checks;
    int            n_fail;
    int            ticks;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(int a, int b, bit sub);
        exp_t e;
        int   s, sa, sb, ss;
        s  = sub ? a - b : a + b;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        ss = sub ? sa - sb : sa + sb;
        e.res = 8'(s & 255);
        e.c   = sub ? (a < b) : (s > 255);
        e.z   = ((s & 255) == 0);
        e.n   = ((s & 255) >= 128);
        e.o   = (ss > 127) || (ss < -128);
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Upstream adder: subtract is A + ~B + 1.
    task automatic drive(int a, int b, bit sub);
        int raw;
        raw      = sub ? a + (255 - b) + 1 : a + b;
        in_sum   = 8'(raw & 255);
        in_carry = (raw > 255);
        in_a_msb = (a >= 128);
        in_b_msb = (b >= 128);
        in_sub   = sub;
        cur      = model(a, b, sub);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sum   = 'x;
        in_carry = 1'bx;
        in_a_msb = 1'bx;
        in_b_msb = 1'bx;
        in_sub   = 1'bx;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() != 0) begin
            chk("out_result", out_result, q[0].res);
            chk("out_carry", out_carry, q[0].c);
            chk("out_zero", out_zero, q[0].z);
            chk("out_neg", out_neg, q[0].n);
            chk("out_ovf", out_ovf, q[0].o);
        end
        chk("result_cnt", result_cnt, cnt_m);
        chk("ovf_sticky", ovf_sticky, sticky_m);
    endtask

    task automatic tick(output bit acc);
        bit   ox, ix, povf;
        exp_t e;
        ox   = (q.size() != 0) && out_ready;
        ix   = in_valid && (q.size() < 2);
        povf = ox && q[0].o;
        e    = cur;
        @(posedge clk);
        if (ox) begin
            void'(q.pop_front());
            cnt_m = cnt_m + 1'b1;
        end
        if (povf) sticky_m = 1'b1;
        else if (ovf_clr) sticky_m = 1'b0;
        if (ix) q.push_back(e);
        ticks++;
        #1;
        check_outputs();
        acc = ix;
    endtask

    task automatic push_item(int a, int b, bit sub);
        bit acc;
        int guard;
        drive(a, b, sub);
        in_valid = 1'b1;
        acc      = 1'b0;
        guard    = 0;
        while (!acc && guard < 50) begin
            tick(acc);
            guard++;
        end
        chk("accept_timeout", acc, 1);
    endtask

    task automatic drain();
        bit acc;
        int guard;
        idle();
        out_ready = 1'b1;
        guard     = 0;
        while (q.size() != 0 && guard < 50) begin
            tick(acc);
            guard++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_result"}, out_result, 0);
        chk({tag, "_flags"}, {out_carry, out_zero, out_neg, out_ovf}, 0);
        chk({tag, "_ovf_sticky"}, ovf_sticky, 0);
        chk({tag, "_result_cnt"}, result_cnt, 0);
    endtask

    initial begin
        bit acc;
        int t0, accepted, guard;

        n_checks  = 0;
        n_fail    = 0;
        ticks     = 0;
        cnt_m     = '0;
        sticky_m  = 1'b0;
        rst       = 1'b1;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        idle();

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // 0x7F + 0x01: signed overflow into negative
        out_ready = 1'b1;
        push_item(8'h7F, 8'h01, 1'b0);
        idle();
        chk("add7f_result", out_result, 8'h80);
        chk("add7f_flags", {out_ovf, out_neg, out_zero, out_carry}, 4'b1100);
        tick(acc);
        chk("add7f_sticky", ovf_sticky, 1);
        chk("add7f_cnt", result_cnt, 1);

        // 0x05 - 0x05: zero, no borrow
        push_item(8'h05, 8'h05, 1'b1);
        idle();
        chk("sub55_flags", {out_ovf, out_neg, out_zero, out_carry}, 4'b0010);
        // 0x03 - 0x05: borrow, negative
        push_item(8'h03, 8'h05, 1'b1);
        idle();
        chk("sub35_result", out_result, 8'hFE);
        chk("sub35_flags", {out_ovf, out_neg, out_zero, out_carry}, 4'b0101);
        // 0x80 - 0x01: signed overflow on subtract
        push_item(8'h80, 8'h01, 1'b1);
        idle();
        chk("sub801_flags", {out_ovf, out_neg, out_zero, out_carry}, 4'b1000);
        // 0xFF + 0x01: carry and zero
        push_item(8'hFF, 8'h01, 1'b0);
        idle();
        chk("addff_flags", {out_ovf, out_neg, out_zero, out_carry}, 4'b0011);
        drain();

        // Backpressure: two held, then in_ready low; release and stream
        out_ready = 1'b0;
        push_item(8'h11, 8'h22, 1'b0);
        push_item(8'h33, 8'h01, 1'b1);
        chk("bp_in_ready_low", in_ready, 0);
        idle();
        repeat (3) tick(acc);
        chk("bp_held_result", out_result, 8'h33);
        out_ready = 1'b1;
        t0 = ticks;
        push_item(8'h40, 8'h40, 1'b0);
        push_item(8'h90, 8'h10, 1'b1);
        push_item(8'hC0, 8'hC0, 1'b0);
        drain();
        chk("bp_drain_cycles", ticks - t0, 5);

        // Clear together with an overflowing transfer: set wins
        ovf_clr = 1'b1;
        tick(acc);
        chk("clr_sticky", ovf_sticky, 0);
        push_item(8'h7F, 8'h01, 1'b0);
        idle();
        tick(acc);
        chk("clr_vs_set_sticky", ovf_sticky, 1);
        tick(acc);
        chk("clr_after", ovf_sticky, 0);
        ovf_clr = 1'b0;

        // Reset mid-stream with both entries occupied
        out_ready = 1'b0;
        push_item(8'h01, 8'h02, 1'b0);
        push_item(8'h7F, 8'h7F, 1'b0);
        idle();
        #2 rst = 1'b1;
        #1;
        check_reset_values("midrst");
        q.delete();
        cnt_m    = '0;
        sticky_m = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("midrst_hold");
        rst = 1'b0;

        // Random traffic, 1000 accepted items
        accepted = 0;
        guard    = 0;
        while (accepted < 1000 && guard < 20000) begin
            in_valid  = ($urandom % 2) == 1;
            out_ready = ($urandom % 2) == 1;
            ovf_clr   = ($urandom_range(0, 7) == 0);
            if (in_valid) drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom % 2 == 1);
            else idle();
            tick(acc);
            if (acc) accepted++;
            guard++;
        end
        chk("rand_accepted", accepted, 1000);
        ovf_clr = 1'b0;
        drain();
        chk("rand_final_cnt", result_cnt, 4'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
